// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: combines an RC4 keystream with a plaintext byte stream.
// After reset or rekey the first DROP_N keystream bytes are discarded.
// Remaining keystream bytes are prefetched into a small FIFO and XORed with
// plaintext to emit msg_len ciphertext bytes per message.
// Keystream left in the FIFO carries over to the next message.
module rc4_stream_xor #(
  parameter int DROP_N     = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] msg_len,
  input  logic        rekey,
  input  logic        ks_valid,
  input  logic [7:0]  ks_data,
  output logic        ks_ready,
  input  logic        pt_valid,
  input  logic [7:0]  pt_data,
  output logic        pt_ready,
  output logic        ct_valid,
  output logic [7:0]  ct_data,
  output logic        ct_last,
  input  logic        ct_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] byte_cnt
);

  localparam int          AW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] DROP_INIT     = 16'(DROP_N);
  localparam logic [AW:0] FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DROP = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;

  logic [7:0]  fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] fifo_cnt_r;
  logic [15:0] drop_cnt_r;
  logic [15:0] remaining_r;
  logic        ct_valid_r, ct_last_r, done_r, busy_r;
  logic [7:0]  ct_data_r;
  logic [15:0] byte_cnt_r;

  logic        ks_ready_s, pt_ready_s;
  logic        ks_hs_s, pt_hs_s, ct_hs_s;
  logic        push_s, pop_s;
  logic        fifo_full_s, fifo_empty_s;
  logic        rekey_acc_s, start_acc_s;
  logic [7:0]  fifo_head_s;

  // Handshake decode: ready signals, accepted control pulses, FIFO push/pop.
  always_comb begin
    fifo_full_s  = (fifo_cnt_r == FIFO_FULL_CNT);
    fifo_empty_s = (fifo_cnt_r == '0);
    fifo_head_s  = fifo_mem_r[rd_ptr_r];
    rekey_acc_s  = (state_r == S_IDLE) && rekey;
    start_acc_s  = (state_r == S_IDLE) && start && !rekey;
    if (state_r == S_DROP) begin
      ks_ready_s = 1'b1;
    end else if (state_r == S_RUN) begin
      ks_ready_s = !fifo_full_s;
    end else begin
      ks_ready_s = 1'b0;
    end
    pt_ready_s = (state_r == S_RUN) && !fifo_empty_s && (remaining_r != 16'd0) &&
                 (!ct_valid_r || ct_ready);
    ks_hs_s    = ks_valid && ks_ready_s;
    pt_hs_s    = pt_valid && pt_ready_s;
    ct_hs_s    = ct_valid_r && ct_ready;
    push_s     = ks_hs_s && (state_r == S_RUN);
    pop_s      = pt_hs_s;
  end

  // Next-state logic for the IDLE/DROP/RUN controller.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_acc_s && (msg_len != 16'd0)) begin
          state_nx_s = (drop_cnt_r != 16'd0) ? S_DROP : S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_DROP: begin
        if (ks_hs_s && (drop_cnt_r == 16'd1)) begin
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_DROP;
        end
      end
      S_RUN: begin
        if (ct_hs_s && ct_last_r) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Keystream FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= ks_data;
    end
  end

  // Keystream FIFO pointers and occupancy; rekey flushes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else if (rekey_acc_s) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + (AW+1)'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - (AW+1)'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Drop counter: armed by reset/rekey, counts down on discarded keystream bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_r <= DROP_INIT;
    end else if (rekey_acc_s) begin
      drop_cnt_r <= DROP_INIT;
    end else if ((state_r == S_DROP) && ks_hs_s) begin
      drop_cnt_r <= drop_cnt_r - 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  // Message bookkeeping and the registered ciphertext/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining_r <= 16'd0;
      ct_valid_r  <= 1'b0;
      ct_data_r   <= 8'd0;
      ct_last_r   <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      byte_cnt_r  <= 16'd0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nx_s != S_IDLE);
      if (start_acc_s) begin
        byte_cnt_r  <= 16'd0;
        remaining_r <= msg_len;
        if (msg_len == 16'd0) begin
          done_r <= 1'b1;
        end
      end
      if (ct_hs_s) begin
        byte_cnt_r <= byte_cnt_r + 16'd1;
        ct_valid_r <= 1'b0;
        if (ct_last_r) begin
          done_r <= 1'b1;
        end
      end
      // A new byte in the same cycle as a ct handshake overrides the clear above.
      if (pt_hs_s) begin
        ct_data_r   <= pt_data ^ fifo_head_s;
        ct_last_r   <= (remaining_r == 16'd1);
        ct_valid_r  <= 1'b1;
        remaining_r <= remaining_r - 16'd1;
      end
    end
  end

  assign ks_ready = ks_ready_s;
  assign pt_ready = pt_ready_s;
  assign ct_valid = ct_valid_r;
  assign ct_data  = ct_data_r;
  assign ct_last  = ct_last_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign byte_cnt = byte_cnt_r;

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Testbench for rc4_stream_xor (DROP_N=2, FIFO_DEPTH=4).
// Reference model: a drop countdown plus a queue of usable keystream bytes
// fed from observed ks handshakes; each accepted plaintext byte is XORed with
// the oldest usable keystream byte to form the expected ciphertext.
module tb_rc4_stream_xor;

  localparam int TB_DROP = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] msg_len;
  logic        rekey;
  logic        ks_valid;
  logic [7:0]  ks_data;
  logic        ks_ready;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_last;
  logic        ct_ready;
  logic        busy;
  logic        done;
  logic [15:0] byte_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] ks_src[$];
  logic [7:0] pt_src[$];
  logic [7:0] ks_avail[$];
  logic [8:0] exp_q[$];
  logic [7:0] got_q[$];
  int         mdrop;
  int         mrem;
  int         n_ks, n_pt, n_ct;

  rc4_stream_xor #(.DROP_N(TB_DROP), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len), .rekey(rekey),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_last(ct_last), .ct_ready(ct_ready),
    .busy(busy), .done(done), .byte_cnt(byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    else return 8'hxx;
  endfunction

  task automatic fill(input int nks, input int npt);
    for (int i = 0; i < nks; i++) ks_src.push_back(8'($urandom_range(255)));
    for (int i = 0; i < npt; i++) pt_src.push_back(8'($urandom_range(255)));
  endtask

  task automatic idle_inputs();
    start = 1'b0; rekey = 1'b0; ks_valid = 1'b0; pt_valid = 1'b0;
    ks_data = 8'h00; pt_data = 8'h00; ct_ready = 1'b1;
  endtask

  // Caller must be at a negedge (or time 0); reset is held for two clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    msg_len = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdrop = TB_DROP;
    ks_avail.delete();
    exp_q.delete();
    #1;
    chk("rst_ks_ready", ks_ready, 0);
    chk("rst_pt_ready", pt_ready, 0);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_ct_last", ct_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
  endtask

  task automatic rekey_with_start();
    @(negedge clk);
    idle_inputs();
    rekey = 1'b1; start = 1'b1; msg_len = 16'd1;
    @(negedge clk);
    idle_inputs();
    mdrop = TB_DROP;
    ks_avail.delete();
    #1;
    chk("rekey_busy", busy, 0);
    chk("rekey_ks_ready", ks_ready, 0);
    chk("rekey_done", done, 0);
  endtask

  // Runs one message; rnd randomizes valid/ready, stall holds ct_ready low
  // after the first ct byte, abort stops right after the first ct handshake.
  task automatic run_msg(input int len, input bit rnd, input int stall, input bit abort);
    bit got_done = 1'b0;
    bit last_prev = 1'b0;
    bit stalled_prev = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] b;
    int stall_left = stall;
    int ct_seen = 0;
    int done_cyc = -1;
    got_q.delete();
    n_ks = 0; n_pt = 0; n_ct = 0;
    mrem = len;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      @(negedge clk);
      if (abort && ct_seen > 0) break;
      start   = (cyc == 0);
      msg_len = 16'(len);
      ks_valid = (ks_src.size() > 0) && (!rnd || $urandom_range(3) != 0);
      ks_data  = ks_valid ? ks_src[0] : 8'h00;
      pt_valid = (pt_src.size() > 0) && (!rnd || $urandom_range(3) != 0);
      pt_data  = pt_valid ? pt_src[0] : 8'h00;
      if (ct_valid && stall_left > 0 && ct_seen >= 1) begin
        ct_ready = 1'b0;
        stall_left--;
      end else begin
        ct_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      end
      #1;
      if (last_prev) chk("done_after_last", done, 1);
      last_prev = 1'b0;
      if (done === 1'b1) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("done_byte_cnt", byte_cnt, len);
        chk("done_busy", busy, 0);
      end
      if (stalled_prev) chk("stall_ct_hold", {ct_valid, ct_data}, {1'b1, held});
      if (ct_valid && !ct_ready) begin
        chk("stall_pt_ready", pt_ready, 0);
        held = ct_data;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      // FIFO pop sees the head before any same-cycle push, so pt goes first.
      if (pt_valid && pt_ready) begin
        b = pt_src.pop_front();
        chk("pt_has_ks", ks_avail.size() > 0, 1);
        if (ks_avail.size() > 0) exp_q.push_back({(mrem == 1), b ^ ks_avail.pop_front()});
        mrem--;
        n_pt++;
      end
      if (ks_valid && ks_ready) begin
        b = ks_src.pop_front();
        if (mdrop > 0) mdrop--;
        else ks_avail.push_back(b);
        n_ks++;
      end
      if (ct_valid && ct_ready) begin
        chk("ct_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("ct_data_last", {ct_last, ct_data}, exp_q.pop_front());
        got_q.push_back(ct_data);
        last_prev = ct_last;
        ct_seen++;
        n_ct++;
      end
    end
    if (!abort) begin
      chk("msg_done", got_done, 1);
      if (len == 0) chk("len0_done_cycle", done_cyc, 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("done_pulse_end", done, 0);
    end
    ks_src.delete();
    pt_src.delete();
  endtask

  initial begin
    int len;
    do_reset();

    // Drop of two bytes, then 55^FF.
    ks_src = '{8'h01, 8'h02, 8'h55};
    pt_src = '{8'hFF};
    run_msg(1, 1'b0, 0, 1'b0);
    chk("drop_ct0", got_at(0), 8'hAA);
    chk("drop_ct_count", got_q.size(), 1);

    // Basic three-byte message (drop already exhausted).
    ks_src = '{8'h10, 8'h20, 8'h30};
    pt_src = '{8'hAA, 8'hBB, 8'hCC};
    run_msg(3, 1'b0, 0, 1'b0);
    chk("basic_ct0", got_at(0), 8'hBA);
    chk("basic_ct1", got_at(1), 8'h9B);
    chk("basic_ct2", got_at(2), 8'hFC);

    // Zero-length message: no handshakes at all.
    ks_src = '{8'h77};
    pt_src = '{8'h66};
    run_msg(0, 1'b0, 0, 1'b0);
    chk("len0_ks_hs", n_ks, 0);
    chk("len0_pt_hs", n_pt, 0);
    chk("len0_ct_hs", n_ct, 0);

    // Continuity: prefetched keystream used by the following message.
    ks_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    pt_src = '{8'h00, 8'h00};
    run_msg(2, 1'b0, 0, 1'b0);
    chk("cont_a0", got_at(0), 8'h11);
    chk("cont_a1", got_at(1), 8'h22);
    pt_src = '{8'h00, 8'h00};
    run_msg(2, 1'b0, 0, 1'b0);
    chk("cont_b0", got_at(0), 8'h33);
    chk("cont_b1", got_at(1), 8'h44);
    chk("cont_b_ks_hs", n_ks, 0);

    // Backpressure: ct_ready low for five cycles mid-stream.
    fill(4, 4);
    run_msg(4, 1'b0, 5, 1'b0);
    chk("bp_count", got_q.size(), 4);

    // Leave keystream in the FIFO, then rekey (with a simultaneous start).
    fill(3, 1);
    run_msg(1, 1'b0, 0, 1'b0);
    rekey_with_start();
    fill(5, 3);
    run_msg(3, 1'b0, 0, 1'b0);
    chk("rekey_ks_hs", n_ks, 5);

    // Reset after the first ciphertext byte of a three-byte message.
    fill(5, 3);
    run_msg(3, 1'b0, 0, 1'b1);
    do_reset();
    fill(4, 2);
    run_msg(2, 1'b0, 0, 1'b0);
    chk("post_rst_ks_hs", n_ks, 4);

    // Randomized messages with random valid/ready gaps.
    for (int m = 0; m < 6; m++) begin
      len = $urandom_range(1, 6);
      fill(len + $urandom_range(0, 2), len);
      run_msg(len, 1'b1, 0, 1'b0);
      chk("rand_count", got_q.size(), len);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
